rr_arbiter4: RTL and testbench
==============================

# rr_arbiter4

Four-requester round-robin arbiter with bounded hold time. It shares one downstream resource among four requesters and issues a registered 2-bit grant index, which an internal 2-to-4 decoder expands into a one-hot grant vector. It sits between the requesting units and the shared datapath, and is the sequencing companion to the decoder blocks.

## Interface

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles one requester keeps the grant while others are waiting; legal range 1..256.
- CNT_W, 8: hold counter width; must satisfy 2^CNT_W >= MAX_HOLD.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- req, input, 4: request lines; req[i] high means requester i wants the resource.
- gnt, output, 4: one-hot grant; all zero when idle.
- gnt_idx, output, 2: index of the granted requester; valid only when gnt_valid is high.
- gnt_valid, output, 1: a grant is active.

## Operation

- State machine: IDLE and GRANT. Registers: state, ptr[1:0] (highest-priority index), gnt_idx, hold_cnt[CNT_W-1:0].
- Reset: state=IDLE, ptr=0, gnt_idx=0, gnt_valid=0, gnt=0000, hold_cnt=0. Reset overrides every other event, including a grant in progress.
- IDLE:
  - If req==0000, stay in IDLE.
  - Otherwise grant the first set bit found searching ptr, ptr+1, ptr+2, ptr+3 (mod 4). Go to GRANT, set hold_cnt=0.
- GRANT, with current index c:
  - Release condition: req[c]==0, or hold_cnt==MAX_HOLD-1.
  - If the release condition is false, hold_cnt increments and the grant is unchanged.
  - On release, ptr becomes c+1 (mod 4). Search the other requesters in order c+1, c+2, c+3.
    - If a request is found, grant it on the same edge with hold_cnt=0. There is no idle cycle between grants.
    - If no other request exists and req[c]==1 (timeout with no contention), re-grant c with hold_cnt=0. The grant stays continuous.
    - Otherwise go to IDLE with gnt_valid=0.
- gnt equals the decode of gnt_idx when gnt_valid=1, and 0000 otherwise.
- Requests are level-sensitive. The arbiter keeps no memory of requests that were dropped.

## Timing

- Requests are sampled on the rising edge. The grant becomes visible immediately after the edge that samples the request, giving 1-cycle latency from request to grant.
- gnt, gnt_idx and gnt_valid are functions of registers only. There is no combinational path from req to any output.
- A requester that drops req in cycle N loses the grant after edge N. The next grant is visible in cycle N+1.
- Under full contention each requester holds the grant for exactly MAX_HOLD cycles.
- With MAX_HOLD=1, grants rotate every cycle when all requesters are active.
- hold_cnt never exceeds MAX_HOLD-1.
- ptr changes only on release or reset.

## Structure

- Shared header arb_defs.vh: state encodings ST_IDLE=1'b0 and ST_GRANT=1'b1, and the requester count constant N_REQ=4.
- Sub-module decoder2to4 (ports A[1:0], EN, D[3:0]): combinational decoder with enable. It is instantiated once and maps gnt_idx and gnt_valid to gnt.
- Keep the priority search as a single combinational function or always block. Do not build a separate module for it.

## Test plan

- Reset: hold rst=1 with req=1111 for 3 cycles, then deassert. During reset gnt=0000 and gnt_valid=0. After the first edge with rst=0, gnt=0001 and gnt_idx=0.
- Lone long request, MAX_HOLD=8: hold req=0100 for 20 cycles. Expect gnt=0100 continuously, with gnt_valid never dropping across timeout re-grants.
- Full contention, MAX_HOLD=8: hold req=1111. Expect gnt sequence 0001 x8, 0010 x8, 0100 x8, 1000 x8, then 0001 again.
- Early release: req=1001 from reset, then drop req[0] after 3 granted cycles. Expect 0001 for 3 cycles, then 1000 in the very next cycle with no gap.
- Pointer memory: grant requester 1, release it with req=0000 and idle for 4 cycles, then apply req=0011. Expect gnt=0001, because ptr=2 and the search runs 2, 3, 0.
- Mid-grant reset: under full contention, pulse rst for one cycle while gnt=0100. Expect gnt=0000 after that edge. Next grant goes to 0001 (ptr=0).

Source files
------------

// File: rtl/rr_arbiter4_pkg.sv
// Shared definitions for the four-requester round-robin arbiter.
package rr_arbiter4_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam int N_REQ = 4;

endpackage

// File: rtl/rr_arbiter4_decoder2to4.sv
// 2-to-4 one-hot decoder with enable; expands the registered grant index.
module decoder2to4 (
  input  logic [1:0] A,
  input  logic       EN,
  output logic [3:0] D
);

  always_comb begin
    D = '0;
    if (EN) D[A] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter for four requesters with a bounded hold time and
// registered grant outputs (no combinational path from req to outputs).
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [1:0]       gnt_idx,
  output logic             gnt_valid
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state, state_n;
  logic [1:0]       ptr, ptr_n;
  logic [1:0]       idx_n;
  logic [CNT_W-1:0] hold_cnt, hold_n;

  // Returns {found, index} of the first set bit scanning base, base+1, ... mod 4.
  function automatic logic [2:0] rr_pick(input logic [N_REQ-1:0] r,
                                         input logic [1:0] base);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = base + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  logic [2:0]       pick_idle, pick_other;
  logic [N_REQ-1:0] others;
  logic             release_now;

  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    idx_n       = gnt_idx;
    hold_n      = hold_cnt;
    others      = req;
    others[gnt_idx] = 1'b0;
    pick_idle   = rr_pick(req, ptr);
    // Masking the current holder lets one 4-way scan from c+1 cover c+1..c+3.
    pick_other  = rr_pick(others, gnt_idx + 2'd1);
    release_now = !req[gnt_idx] || (hold_cnt == HOLD_LAST);

    unique case (state)
      ST_IDLE: begin
        if (pick_idle[2]) begin
          state_n = ST_GRANT;
          idx_n   = pick_idle[1:0];
          hold_n  = '0;
        end
      end
      ST_GRANT: begin
        if (!release_now) begin
          hold_n = hold_cnt + 1'b1;
        end else begin
          ptr_n  = gnt_idx + 2'd1;
          hold_n = '0;
          if (pick_other[2]) begin
            idx_n = pick_other[1:0];
          end else if (!req[gnt_idx]) begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      gnt_idx  <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      gnt_idx  <= idx_n;
      hold_cnt <= hold_n;
    end
  end

  assign gnt_valid = (state == ST_GRANT);

  decoder2to4 u_dec (
    .A  (gnt_idx),
    .EN (gnt_valid),
    .D  (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4: behavioural model compared every cycle
// plus directed scenarios with hand-computed literal grants.
module tb_rr_arbiter4;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;

  int checks   = 0;
  int failures = 0;

  rr_arbiter4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: who holds the grant and for how many cycles so far.
  int m_ptr = 0, m_cur = 0, m_held = 0;
  bit m_valid = 0;

  always @(posedge clk) begin
    int found;
    if (rst) begin
      m_ptr = 0; m_cur = 0; m_held = 0; m_valid = 0;
    end else if (!m_valid) begin
      found = -1;
      for (int k = 0; k < 4; k++)
        if (found < 0 && req[(m_ptr + k) % 4]) found = (m_ptr + k) % 4;
      if (found >= 0) begin
        m_valid = 1; m_cur = found; m_held = 1;
      end
    end else if (req[m_cur] && m_held < MAX_HOLD) begin
      m_held++;
    end else begin
      m_ptr = (m_cur + 1) % 4;
      found = -1;
      for (int k = 1; k < 4; k++)
        if (found < 0 && req[(m_cur + k) % 4]) found = (m_cur + k) % 4;
      if (found >= 0) begin
        m_cur = found; m_held = 1;
      end else if (req[m_cur]) begin
        m_held = 1;
      end else begin
        m_valid = 0; m_held = 0;
      end
    end
    #1;
    check("model_valid", {7'd0, gnt_valid}, {7'd0, m_valid});
    check("model_gnt", {4'd0, gnt}, m_valid ? (8'd1 << m_cur) : 8'd0);
    if (m_valid) check("model_idx", {6'd0, gnt_idx}, 8'(m_cur));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_g;
    bit         seen;
    rst = 1'b1;
    req = 4'b1111;

    // Reset held for three cycles under full request.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_gnt", {4'd0, gnt}, 8'd0);
      check("reset_valid", {7'd0, gnt_valid}, 8'd0);
    end
    rst = 1'b0;

    // Full contention rotation: eight cycles each, then back to 0.
    for (int k = 1; k <= 33; k++) begin
      tick();
      exp_g = 4'b0001 << (((k - 1) / MAX_HOLD) % 4);
      check("rotate_gnt", {4'd0, gnt}, {4'd0, exp_g});
      if (k == 1) check("first_idx", {6'd0, gnt_idx}, 8'd0);
    end

    // Mid-grant reset while requester 2 holds the grant.
    seen = 0;
    for (int i = 0; i < 64 && !seen; i++) begin
      if (gnt == 4'b0100) seen = 1;
      else tick();
    end
    check("reach_0100", {7'd0, seen}, 8'd1);
    rst = 1'b1;
    tick();
    check("midrst_gnt", {4'd0, gnt}, 8'd0);
    rst = 1'b0;
    tick();
    check("after_rst_gnt", {4'd0, gnt}, 8'b0001);

    // Lone long request across timeout re-grants.
    do_reset();
    req = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("lone_gnt", {4'd0, gnt}, 8'b0100);
      check("lone_valid", {7'd0, gnt_valid}, 8'd1);
    end

    // Early release hands over on the next edge without a gap.
    req = 4'b0000;
    do_reset();
    req = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("early_hold", {4'd0, gnt}, 8'b0001);
    end
    req = 4'b1000;
    tick();
    check("early_next", {4'd0, gnt}, 8'b1000);

    // Pointer memory: after serving 1, the search starts at 2.
    req = 4'b0000;
    do_reset();
    req = 4'b0010;
    tick();
    check("ptr_grant1", {4'd0, gnt}, 8'b0010);
    req = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("ptr_idle", {4'd0, gnt}, 8'd0);
    end
    req = 4'b0011;
    tick();
    check("ptr_search", {4'd0, gnt}, 8'b0001);
    check("ptr_idx", {6'd0, gnt_idx}, 8'd0);

    req = 4'b0000;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
